// File: rtl/regfile_sequencer.sv
// Sequencer that streams registers 1..31 of regfile32 out (dump) or in (load).
// Dumps take two cycles per beat: one for the read, one holding the registered beat.
module regfile_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_dump,
  input  logic        start_load,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_read1,
  output logic [4:0]  rf_read2,
  input  logic [31:0] rf_out1,
  output logic [4:0]  rf_writeto,
  output logic [31:0] rf_writedat,
  output logic        rf_writeenable,
  input  logic [31:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [31:0] dump_data,
  output logic [4:0]  dump_addr,
  output logic        dump_valid,
  input  logic        dump_ready
);

  typedef enum logic [2:0] {IDLE, DUMP_RD, DUMP_HOLD, LOAD, DONE} state_t;

  localparam logic [4:0] FIRST = 5'd1;
  localparam logic [4:0] LAST  = 5'd31;

  state_t     state, state_nxt;
  logic [4:0] addr, addr_nxt;
  logic       capture;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= FIRST;
      dump_data <= '0;
      dump_addr <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      if (capture) begin
        dump_data <= rf_out1;
        dump_addr <= addr;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    capture        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    rf_read1       = '0;
    rf_read2       = '0;
    rf_writeto     = '0;
    rf_writedat    = '0;
    rf_writeenable = 1'b0;
    load_ready     = 1'b0;
    dump_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (start_dump) begin
          state_nxt = DUMP_RD;
          addr_nxt  = FIRST;
        end else if (start_load) begin
          state_nxt = LOAD;
          addr_nxt  = FIRST;
        end
      end
      DUMP_RD: begin
        busy      = 1'b1;
        rf_read1  = addr;
        capture   = 1'b1;
        state_nxt = DUMP_HOLD;
      end
      DUMP_HOLD: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (addr == LAST) begin
            state_nxt = DONE;
          end else begin
            addr_nxt  = addr + 5'd1;
            state_nxt = DUMP_RD;
          end
        end
      end
      LOAD: begin
        busy = 1'b1;
        // Reset is gated in here so the edge that samples reset low commits no write.
        load_ready     = !abort && reset;
        rf_writeto     = addr;
        rf_writedat    = load_data;
        rf_writeenable = load_valid && load_ready;
        if (load_valid && load_ready) begin
          if (addr == LAST) state_nxt = DONE;
          else              addr_nxt  = addr + 5'd1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      addr_nxt  = FIRST;
      capture   = 1'b0;
    end
  end

endmodule
